// File: rtl/u_mem_wb_reg_pkg.sv
// Shared MIPS pipeline definitions: datapath width, byte-lane encodings,
// the MEM/WB control bundle and a byte-extension helper.
package mips_pkg;

    localparam int XLEN = 32;

    // Little-endian byte lanes selected by data address bits [1:0].
    localparam logic [1:0] BYTE_SEL_0 = 2'd0;  // bits [7:0]
    localparam logic [1:0] BYTE_SEL_1 = 2'd1;  // bits [15:8]
    localparam logic [1:0] BYTE_SEL_2 = 2'd2;  // bits [23:16]
    localparam logic [1:0] BYTE_SEL_3 = 2'd3;  // bits [31:24]

    // Control bits travelling from MEM into WB alongside the data.
    typedef struct packed {
        logic valid;
        logic reg_wr;
        logic mem_to_reg;
        logic word;
        logic is_unsigned;
    } mem_wb_ctrl_t;

    // Widen one byte to XLEN: zero-extend for lbu, sign-extend for lb.
    function automatic logic [XLEN-1:0] extend_byte(input logic [7:0] b,
                                                     input logic       zero_ext);
        logic [XLEN-1:0] r;
        if (zero_ext) begin
            r = {{(XLEN-8){1'b0}}, b};
        end else begin
            r = {{(XLEN-8){b[7]}}, b};
        end
        return r;
    endfunction

endpackage

// File: rtl/u_mem_wb_reg_load_align.sv
// Combinational load alignment: picks the addressed byte lane out of the
// aligned memory word and extends it; word loads pass through unchanged.
// Kept separate so a halfword mode can be added without touching the
// pipeline register.
module u_load_align
    import mips_pkg::*;
(
    input  logic            i_word,
    input  logic            i_unsigned,
    input  logic [1:0]      i_byte_sel,
    input  logic [XLEN-1:0] i_mem_data,
    output logic [XLEN-1:0] o_load_data
);

    logic [7:0] lane_byte;

    // Select the addressed byte lane (little-endian).
    always_comb begin
        lane_byte = i_mem_data[7:0];
        case (i_byte_sel)
            BYTE_SEL_0: lane_byte = i_mem_data[7:0];
            BYTE_SEL_1: lane_byte = i_mem_data[15:8];
            BYTE_SEL_2: lane_byte = i_mem_data[23:16];
            BYTE_SEL_3: lane_byte = i_mem_data[31:24];
            default:    lane_byte = i_mem_data[7:0];
        endcase
    end

    // Word loads ignore the lane select; a misaligned word still returns
    // the aligned word, the pipeline register flags it separately.
    always_comb begin
        o_load_data = i_mem_data;
        if (!i_word) begin
            o_load_data = extend_byte(lane_byte, i_unsigned);
        end
    end

endmodule

// File: rtl/u_mem_wb_reg.sv
// MEM/WB pipeline register. Captures load/ALU write-back data and control
// from the MEM stage, qualifies the register-file write, keeps a sticky
// misaligned-word-load flag and counts retired (captured valid) instructions.
//
// Handshake: there is no ready/back-pressure path. i_u_mem_wb_valid marks a
// real instruction on the MEM-stage inputs; it is consumed on any rising
// edge without flush or stall. o_u_mem_wb_valid marks a real instruction in
// WB for exactly the cycles it is held. Flush beats stall beats load.
module u_mem_wb_reg
    import mips_pkg::*;
#(
    parameter int RETIRE_W   = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_sys_clock,
    input  logic                  i_sys_reset_n,
    input  logic                  i_u_mem_wb_stall,
    input  logic                  i_u_mem_wb_flush,
    input  logic                  i_u_mem_wb_valid,
    input  logic                  i_u_mem_wb_reg_wr,
    input  logic                  i_u_mem_wb_mem_to_reg,
    input  logic                  i_u_mem_wb_word,
    input  logic                  i_u_mem_wb_unsigned,
    input  logic [1:0]            i_u_mem_wb_byte_sel,
    input  logic [31:0]           i_u_mem_wb_alu_result,
    input  logic [31:0]           i_u_mem_wb_mem_data,
    input  logic [REG_ADDR_W-1:0] i_u_mem_wb_dest_reg,
    output logic                  o_u_mem_wb_valid,
    output logic                  o_u_mem_wb_reg_wr,
    output logic [REG_ADDR_W-1:0] o_u_mem_wb_dest_reg,
    output logic [31:0]           o_u_mem_wb_wb_data,
    output logic                  o_u_mem_wb_fwd_en,
    output logic                  o_u_mem_wb_misalign,
    output logic [RETIRE_W-1:0]   o_u_mem_wb_retire_cnt
);

    mem_wb_ctrl_t          ctrl_in;
    logic [XLEN-1:0]       load_data;
    logic [XLEN-1:0]       wb_data_next;
    logic                  load_en;
    logic                  misalign_hit;

    logic                  valid_q,    valid_d;
    logic                  reg_wr_q,   reg_wr_d;
    logic [REG_ADDR_W-1:0] dest_q,     dest_d;
    logic [XLEN-1:0]       wb_data_q,  wb_data_d;
    logic                  misalign_q, misalign_d;
    logic [RETIRE_W-1:0]   retire_q,   retire_d;

    assign ctrl_in = '{valid:       i_u_mem_wb_valid,
                       reg_wr:      i_u_mem_wb_reg_wr,
                       mem_to_reg:  i_u_mem_wb_mem_to_reg,
                       word:        i_u_mem_wb_word,
                       is_unsigned: i_u_mem_wb_unsigned};

    u_load_align u_align (
        .i_word      (ctrl_in.word),
        .i_unsigned  (ctrl_in.is_unsigned),
        .i_byte_sel  (i_u_mem_wb_byte_sel),
        .i_mem_data  (i_u_mem_wb_mem_data),
        .o_load_data (load_data)
    );

    // Write-back source mux and edge classification.
    always_comb begin
        wb_data_next = ctrl_in.mem_to_reg ? load_data : i_u_mem_wb_alu_result;
        load_en      = !i_u_mem_wb_flush && !i_u_mem_wb_stall;
        misalign_hit = ctrl_in.valid && ctrl_in.mem_to_reg && ctrl_in.word &&
                       (i_u_mem_wb_byte_sel != BYTE_SEL_0);
    end

    // Next-state: hold by default, bubble on flush or invalid load, capture otherwise.
    always_comb begin
        valid_d    = valid_q;
        reg_wr_d   = reg_wr_q;
        dest_d     = dest_q;
        wb_data_d  = wb_data_q;
        misalign_d = misalign_q;
        retire_d   = retire_q;
        if (i_u_mem_wb_flush || (load_en && !ctrl_in.valid)) begin
            valid_d   = 1'b0;
            reg_wr_d  = 1'b0;
            dest_d    = '0;
            wb_data_d = '0;
        end else if (load_en) begin
            valid_d    = 1'b1;
            // Writes to $0 are dropped here so WB and forwarding never see them.
            reg_wr_d   = ctrl_in.reg_wr && (i_u_mem_wb_dest_reg != '0);
            dest_d     = i_u_mem_wb_dest_reg;
            wb_data_d  = wb_data_next;
            misalign_d = misalign_q | misalign_hit;
            retire_d   = retire_q + RETIRE_W'(1);
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge i_sys_clock or negedge i_sys_reset_n) begin
        if (!i_sys_reset_n) begin
            valid_q    <= 1'b0;
            reg_wr_q   <= 1'b0;
            dest_q     <= '0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
            retire_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            reg_wr_q   <= reg_wr_d;
            dest_q     <= dest_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
            retire_q   <= retire_d;
        end
    end

    assign o_u_mem_wb_valid      = valid_q;
    assign o_u_mem_wb_reg_wr     = reg_wr_q;
    assign o_u_mem_wb_fwd_en     = reg_wr_q;
    assign o_u_mem_wb_dest_reg   = dest_q;
    assign o_u_mem_wb_wb_data    = wb_data_q;
    assign o_u_mem_wb_misalign   = misalign_q;
    assign o_u_mem_wb_retire_cnt = retire_q;

endmodule

// File: tb/tb_u_mem_wb_reg.sv
// Directed bench for u_mem_wb_reg with a 4-bit retire counter so the wrap
// is reachable. The driver pushes the expected post-edge output snapshot;
// the monitor pops and compares one snapshot after every rising edge.
module tb_u_mem_wb_reg;

    localparam int RW    = 4;
    localparam int AW    = 5;
    localparam int EXP_W = 4 + AW + RW + 32;

    logic          clk;
    logic          rst_n;
    logic          stall, flush, valid, reg_wr, m2r, word, uns;
    logic [1:0]    sel;
    logic [31:0]   alu, mem;
    logic [AW-1:0] dest;

    logic          o_valid, o_reg_wr, o_fwd, o_mis;
    logic [AW-1:0] o_dest;
    logic [31:0]   o_wb;
    logic [RW-1:0] o_ret;

    logic [EXP_W-1:0] exp_q[$];

    // Model of the registered state after the next edge.
    logic          m_valid, m_reg_wr, m_mis;
    logic [AW-1:0] m_dest;
    logic [31:0]   m_wb;
    logic [RW-1:0] m_ret;

    int checks = 0;
    int errors = 0;

    u_mem_wb_reg #(.RETIRE_W(RW), .REG_ADDR_W(AW)) dut (
        .i_sys_clock           (clk),
        .i_sys_reset_n         (rst_n),
        .i_u_mem_wb_stall      (stall),
        .i_u_mem_wb_flush      (flush),
        .i_u_mem_wb_valid      (valid),
        .i_u_mem_wb_reg_wr     (reg_wr),
        .i_u_mem_wb_mem_to_reg (m2r),
        .i_u_mem_wb_word       (word),
        .i_u_mem_wb_unsigned   (uns),
        .i_u_mem_wb_byte_sel   (sel),
        .i_u_mem_wb_alu_result (alu),
        .i_u_mem_wb_mem_data   (mem),
        .i_u_mem_wb_dest_reg   (dest),
        .o_u_mem_wb_valid      (o_valid),
        .o_u_mem_wb_reg_wr     (o_reg_wr),
        .o_u_mem_wb_dest_reg   (o_dest),
        .o_u_mem_wb_wb_data    (o_wb),
        .o_u_mem_wb_fwd_en     (o_fwd),
        .o_u_mem_wb_misalign   (o_mis),
        .o_u_mem_wb_retire_cnt (o_ret)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [EXP_W-1:0] pack(input logic v, input logic w,
                                              input logic f, input logic mi,
                                              input logic [AW-1:0] d,
                                              input logic [RW-1:0] r,
                                              input logic [31:0] data);
        return {v, w, f, mi, d, r, data};
    endfunction

    task automatic model_reset();
        m_valid = 0; m_reg_wr = 0; m_mis = 0; m_dest = '0; m_wb = '0; m_ret = '0;
    endtask

    // Drive one MEM-stage cycle; exp_wb is the hand-computed write-back word.
    task automatic drive(input logic v, input logic rw, input logic mtr,
                         input logic wd, input logic un, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] md,
                         input logic [AW-1:0] d, input logic st, input logic fl,
                         input logic [31:0] exp_wb);
        @(negedge clk);
        valid = v; reg_wr = rw; m2r = mtr; word = wd; uns = un; sel = s;
        alu = a; mem = md; dest = d; stall = st; flush = fl;
        if (fl || (!st && !v)) begin
            m_valid = 0; m_reg_wr = 0; m_dest = '0; m_wb = '0;
        end else if (!st) begin
            m_valid  = 1;
            m_reg_wr = rw && (d != '0);
            m_dest   = d;
            m_wb     = exp_wb;
            if (mtr && wd && (s != 2'd0)) m_mis = 1;
            m_ret    = m_ret + 1'b1;
        end
        exp_q.push_back(pack(m_valid, m_reg_wr, m_reg_wr, m_mis, m_dest, m_ret, m_wb));
    endtask

    task automatic wait_drained();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #3;
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({o_valid, o_reg_wr, o_fwd, o_mis, o_dest, o_ret, o_wb} != '0) begin
            errors++;
            $display("FAIL %s: v=%0b rw=%0b fwd=%0b mis=%0b dest=%0d ret=%0d wb=%h, required all 0",
                     name, o_valid, o_reg_wr, o_fwd, o_mis, o_dest, o_ret, o_wb);
        end
    endtask

    // Async reset between edges; outputs must clear without a clock edge.
    task automatic async_reset(input string name);
        wait_drained();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero(name);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor / scoreboard
    initial begin
        logic [EXP_W-1:0] e, a;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {o_valid, o_reg_wr, o_fwd, o_mis, o_dest, o_ret, o_wb};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL wb_out @%0t: got v=%0b rw=%0b fwd=%0b mis=%0b dest=%0d ret=%0d wb=%h, required v=%0b rw=%0b fwd=%0b mis=%0b dest=%0d ret=%0d wb=%h",
                             $time, a[EXP_W-1], a[EXP_W-2], a[EXP_W-3], a[EXP_W-4],
                             a[RW+32+AW-1 -: AW], a[RW+31 -: RW], a[31:0],
                             e[EXP_W-1], e[EXP_W-2], e[EXP_W-3], e[EXP_W-4],
                             e[RW+32+AW-1 -: AW], e[RW+31 -: RW], e[31:0]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        rst_n = 1'b0;
        stall = 0; flush = 0; valid = 0; reg_wr = 0; m2r = 0; word = 0; uns = 0;
        sel = 2'd0; alu = '0; mem = '0; dest = '0;
        model_reset();
        #2 check_zero("reset_initial");
        #10 rst_n = 1'b1;

        //    v rw m2r wd un sel  alu           mem           dest st fl exp_wb
        drive(1, 1, 1, 1, 0, 2'd0, 32'h0000_1000, 32'h8765_4321, 5'd8, 0, 0, 32'h8765_4321);
        drive(1, 1, 1, 0, 0, 2'd2, 32'h0000_1002, 32'h8765_4321, 5'd3, 0, 0, 32'h0000_0065);
        drive(1, 1, 1, 0, 0, 2'd3, 32'h0000_1003, 32'h8765_4321, 5'd4, 0, 0, 32'hFFFF_FF87);
        drive(1, 1, 1, 0, 1, 2'd3, 32'h0000_1003, 32'h8765_4321, 5'd5, 0, 0, 32'h0000_0087);
        drive(1, 1, 1, 0, 1, 2'd0, 32'h0000_1000, 32'h8765_4321, 5'd6, 0, 0, 32'h0000_0021);
        drive(1, 1, 1, 0, 0, 2'd1, 32'h0000_1001, 32'h0000_8000, 5'd7, 0, 0, 32'hFFFF_FF80);
        // ALU path to $0: write suppressed
        drive(1, 1, 0, 0, 0, 2'd0, 32'h0000_0FF0, 32'hDEAD_BEEF, 5'd0, 0, 0, 32'h0000_0FF0);
        // ALU path, reg_wr=0 to nonzero dest
        drive(1, 0, 0, 1, 0, 2'd0, 32'h1234_0000, 32'h0, 5'd12, 0, 0, 32'h1234_0000);
        // lw to $9, then stall three cycles with changing inputs
        drive(1, 1, 1, 1, 0, 2'd0, 32'h0000_2000, 32'h1234_5678, 5'd9, 0, 0, 32'h1234_5678);
        drive(1, 1, 0, 0, 0, 2'd0, 32'hAAAA_0001, 32'h1111_1111, 5'd10, 1, 0, 32'h0);
        drive(0, 0, 1, 1, 0, 2'd1, 32'hAAAA_0002, 32'h2222_2222, 5'd11, 1, 0, 32'h0);
        drive(1, 1, 1, 1, 0, 2'd2, 32'hAAAA_0003, 32'h3333_3333, 5'd13, 1, 0, 32'h0);
        // flush together with stall
        drive(1, 1, 1, 1, 0, 2'd0, 32'hAAAA_0004, 32'h4444_4444, 5'd14, 1, 1, 32'h0);
        drive(1, 1, 0, 0, 0, 2'd0, 32'h0000_0055, 32'h0, 5'd15, 0, 0, 32'h0000_0055);
        // invalid input captures a bubble, no count
        drive(0, 1, 1, 1, 0, 2'd0, 32'h0000_0066, 32'h7777_7777, 5'd16, 0, 0, 32'h0);

        async_reset("reset_mid_op");

        // misaligned lw sets the sticky flag, data still the aligned word
        drive(1, 1, 1, 1, 0, 2'd1, 32'h0000_3001, 32'hAABB_CCDD, 5'd4, 0, 0, 32'hAABB_CCDD);
        for (int i = 0; i < 5; i++) begin
            logic [31:0] d;
            d = 32'h0101_0000 + $urandom_range(0, 255);
            drive(1, 1, 1, 1, 0, 2'd0, 32'h0000_4000, d, 5'(i + 1), 0, 0, d);
        end
        drive(1, 1, 0, 0, 0, 2'd0, 32'h0000_0077, 32'h0, 5'd2, 0, 1, 32'h0);

        async_reset("reset_before_wrap");

        // 17 valid loads on a 4-bit counter end at 1
        for (int i = 0; i < 17; i++) begin
            drive(1, 1, 0, 0, 0, 2'd0, 32'(i * 3), 32'h0, 5'(i + 1), 0, 0, 32'(i * 3));
        end

        wait_drained();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time bound
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, required completion before 20000");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
